ofdm_cp_serializer: RTL
=======================

Name: ofdm_cp_serializer

Overview:
Transmit-side consumer of the FFT/IFFT core's parallel result vector, working in IFFT mode. It captures one N-sample complex symbol when the core's result-valid level rises. It then emits the symbol as a serial stream with a valid/ready handshake: first the CP_LEN cyclic-prefix samples, then all N body samples. It sits between the IFFT output and the DAC/channel model in the OFDM transmit chain.

Parameters:
N, 64, samples per OFDM symbol
CP_LEN, 16, cyclic-prefix length; legal range 0 <= CP_LEN < N
RE_W, 16, real-part width (signed)
IM_W, 16, imaginary-part width (signed)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; synchronous, active-low
vec_re  in  RE_W*N  symbol real parts; sample k at [k*RE_W +: RE_W]
vec_im  in  IM_W*N  symbol imaginary parts; sample k at [k*IM_W +: IM_W]
vec_valid  in  1  level; a 0->1 transition marks a new vector (sticky-high source allowed)
vec_busy  out  1  high while a captured symbol is not yet fully sent
s_re  out  RE_W  serial real sample
s_im  out  IM_W  serial imaginary sample
s_valid  out  1  serial sample valid
s_ready  in  1  downstream ready
s_first  out  1  qualifies the first sample of the symbol (first CP sample, or body sample 0 if CP_LEN=0)
s_last  out  1  qualifies body sample N-1
overrun  out  1  sticky; a vector edge arrived while busy and was dropped

Behaviour:
- Reset, sampled on clk when rst_n=0: all outputs 0; state IDLE; index 0; vec_valid history register 0; capture buffer 0.
  - Because history resets to 0, a vec_valid already high after reset counts as an edge.
- Edge: edge = vec_valid & ~vec_valid_q; vec_valid_q is updated every cycle.
- FSM states: IDLE, CP, BODY.
- IDLE:
  - On edge at cycle t, latch vec_re/vec_im into the buffer.
  - At t+1: state=CP (BODY if CP_LEN=0), vec_busy=1, s_valid=1, s_first=1, index=N-CP_LEN (0 if CP_LEN=0).
  - Latency from edge to first s_valid is 1 cycle.
- CP:
  - Output buffer sample idx.
  - On handshake (s_valid & s_ready), idx+1.
  - After the handshake at idx=N-1: state=BODY, idx=0.
- BODY:
  - Output buffer sample idx.
  - On handshake, idx+1.
  - s_last=1 when idx=N-1.
  - After the handshake at idx=N-1: state=IDLE, s_valid=0, vec_busy=0 on the next cycle.
- Total handshakes per symbol: CP_LEN+N.
- Handshake rules:
  - While s_valid=1 and s_ready=0, s_re/s_im/s_first/s_last are held stable.
  - s_valid never drops before its handshake.
  - s_first/s_last are 0 whenever s_valid=0.
- Back-to-back symbols: an edge in the same cycle as the final BODY handshake is accepted.
  - It captures the new vector, and the next cycle goes straight to CP with s_valid held at 1.
  - There is no bubble and no overrun.
- Overrun: an edge in any other busy cycle is ignored; the buffer and stream are unaffected and overrun is set to 1. Only reset clears overrun.
- Data path: pure selection, no arithmetic; sample values pass bit-exact.
  - The buffer is written only on an accepted edge.
  - Index counter width is clog2(N).
- Reset mid-symbol: the stream aborts immediately and the next cycle shows s_valid=0; no partial resume.

Decomposition:
- Shared package ofdm_pkg holds:
  - the N, CP_LEN, RE_W, IM_W defaults shared with the FFT core;
  - the FSM state enum {IDLE, CP, BODY};
  - the index-width constant.
- Optional sub-module ofdm_sample_sel: parameterised N-to-1 complex sample mux (buffer, idx -> re, im). The FSM, counter and edge logic stay in the top.

Test Plan:
- Basic, CP_LEN=16, s_ready=1, sample k = (re=k, im=-k), raise vec_valid → s_valid 1 cycle later.
  - 80 consecutive samples: re=48..63 then 0..63.
  - s_first only on re=48, s_last only on re=63 (the 80th).
  - vec_busy low on the cycle after.
- Backpressure: same vector with s_ready toggling 1,0,0,1,... → identical 80-sample sequence; outputs stable during every s_ready=0 cycle; no duplicates or drops.
- Sticky valid: vec_valid held high for 500 cycles → exactly one symbol (80 handshakes); no retransmission; overrun stays 0.
- Overrun: second edge at handshake 30 → first symbol completes unchanged and overrun=1. An edge on the final-handshake cycle of another run → second symbol starts next cycle with no bubble and no overrun.
- CP_LEN=0 build → 64 samples re=0..63; s_first on re=0, s_last on re=63.
- Reset mid-symbol at handshake 40 → next cycle s_valid=0, vec_busy=0, overrun=0. After rst_n returns high, a held-high vec_valid triggers a fresh symbol starting at re=48.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared OFDM defaults and types used by the FFT/IFFT core and its transmit-side consumers.
package ofdm_pkg;

   localparam int N_DEF      = 64;
   localparam int CP_LEN_DEF = 16;
   localparam int RE_W_DEF   = 16;
   localparam int IM_W_DEF   = 16;

   typedef enum logic [1:0] {
      IDLE,
      CP,
      BODY
   } state_t;

   // A single-sample symbol still needs a one-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W_DEF = idx_width(N_DEF);

endpackage

// File: rtl/ofdm_sample_sel.sv
// N-to-1 complex sample multiplexer over a flat symbol buffer.
module ofdm_sample_sel
   import ofdm_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int RE_W = RE_W_DEF,
   parameter int IM_W = IM_W_DEF
) (
   input  logic [RE_W*N-1:0]       buf_re,
   input  logic [IM_W*N-1:0]       buf_im,
   input  logic [idx_width(N)-1:0] idx,
   output logic [RE_W-1:0]         re,
   output logic [IM_W-1:0]         im
);

   assign re = buf_re[idx*RE_W +: RE_W];
   assign im = buf_im[idx*IM_W +: IM_W];

endmodule

// File: rtl/ofdm_cp_serializer.sv
// Captures one IFFT result vector on a rising vec_valid and streams it out as
// cyclic prefix followed by the full body over a valid/ready interface.
module ofdm_cp_serializer
   import ofdm_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int CP_LEN = CP_LEN_DEF,
   parameter int RE_W   = RE_W_DEF,
   parameter int IM_W   = IM_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RE_W*N-1:0] vec_re,
   input  logic [IM_W*N-1:0] vec_im,
   input  logic              vec_valid,
   output logic              vec_busy,
   output logic [RE_W-1:0]   s_re,
   output logic [IM_W-1:0]   s_im,
   output logic              s_valid,
   input  logic              s_ready,
   output logic              s_first,
   output logic              s_last,
   output logic              overrun
);

   localparam int IDX_W = idx_width(N);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'((N > 1) ? N - 2 : 0);
   localparam logic [IDX_W-1:0] IDX_START  = (CP_LEN == 0) ? '0 : IDX_W'(N - CP_LEN);
   localparam state_t           ST_START   = (CP_LEN == 0) ? BODY : CP;
   localparam logic             LAST_START = (CP_LEN == 0) && (N == 1);

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic                vec_valid_q;
   logic [RE_W*N-1:0]   buf_re;
   logic [IM_W*N-1:0]   buf_im;

   logic vec_edge;
   logic hs;
   logic final_hs;
   logic accept;

   assign vec_edge = vec_valid & ~vec_valid_q;
   assign hs       = s_valid & s_ready;
   assign final_hs = hs && (state == BODY) && (idx == IDX_LAST);
   // An edge on the final body handshake starts the next symbol with no bubble.
   assign accept   = vec_edge && ((state == IDLE) || final_hs);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         vec_valid_q <= 1'b0;
         // NOTE: the capture buffer is reset on purpose so the idle stream reads zero.
         buf_re      <= '0;
         buf_im      <= '0;
         vec_busy    <= 1'b0;
         s_valid     <= 1'b0;
         s_first     <= 1'b0;
         s_last      <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every branch sees pre-edge state.
         vec_valid_q <= vec_valid;

         // In IDLE every edge is accepted, so a rejected edge implies busy.
         if (vec_edge && !accept)
            overrun <= 1'b1;

         if (accept) begin
            buf_re   <= vec_re;
            buf_im   <= vec_im;
            state    <= ST_START;
            idx      <= IDX_START;
            vec_busy <= 1'b1;
            s_valid  <= 1'b1;
            s_first  <= 1'b1;
            s_last   <= LAST_START;
         end else if (hs) begin
            s_first <= 1'b0;
            unique case (state)
               CP: begin
                  if (idx == IDX_LAST) begin
                     state  <= BODY;
                     idx    <= '0;
                     s_last <= (N == 1);
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
               BODY: begin
                  if (idx == IDX_LAST) begin
                     state    <= IDLE;
                     idx      <= '0;
                     vec_busy <= 1'b0;
                     s_valid  <= 1'b0;
                     s_last   <= 1'b0;
                  end else begin
                     idx    <= idx + IDX_W'(1);
                     s_last <= (idx == IDX_PENULT);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   ofdm_sample_sel #(
      .N    (N),
      .RE_W (RE_W),
      .IM_W (IM_W)
   ) u_sel (
      .buf_re (buf_re),
      .buf_im (buf_im),
      .idx    (idx),
      .re     (s_re),
      .im     (s_im)
   );

endmodule
